// File: rtl/lab5_mem_arbiter.sv
// lab5_mem_arbiter: two-requester round-robin arbiter and access sequencer
// placed in front of the single-ported Lab5Memory (256x32).
//
// Requesters A and B each present req/we/addr/wdata. One access at a time is
// issued to the memory port, and completion is signalled with a one-cycle ack.
// On a read, the data is returned in the requester's rdata register at the same
// time as the ack.
//
// Optional build macro: LAB5_ARB_STATS_EN
//   When defined, the module has two extra outputs, a_grants and b_grants.
//   These are 16-bit saturating counters of grants per requester.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | no access in flight; arbitrate on any req, latch the winner
// ISSUE  | memory port driven with latched addr/data, mem_write = latched we
// WAIT   | READ_LAT cycles for mem_dout; last WAIT edge captures read data
// ACK    | winner's ack high for exactly this cycle, then back to IDLE

module lab5_mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_write,
  output logic [DW-1:0] mem_in,
  input  logic [DW-1:0] mem_dout
`ifdef LAB5_ARB_STATS_EN
  ,
  output logic [15:0]   a_grants,
  output logic [15:0]   b_grants
`endif
);

  // The wait counter counts down from READ_LAT-1 to zero. It needs at least one bit.
  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          last_grant;  // 0 = A, 1 = B
  logic          grant_b;     // winner of the access currently in flight
  logic          cur_we;      // latched we of the access currently in flight
  logic          pick_b;
  logic          any_req;

  // Round-robin pick: a lone request wins. On a tie, the requester not served last wins.
  always_comb begin
    any_req = a_req | b_req;
    pick_b  = b_req & (~a_req | ~last_grant);
  end

  // Access sequencer. All memory-port and requester outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      last_grant <= 1'b1;
      grant_b    <= 1'b0;
      cur_we     <= 1'b0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      mem_addr   <= '0;
      mem_write  <= 1'b0;
      mem_in     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_b    <= pick_b;
            last_grant <= pick_b;
            cur_we     <= pick_b ? b_we : a_we;
            mem_write  <= pick_b ? b_we : a_we;
            mem_addr   <= pick_b ? b_addr : a_addr;
            mem_in     <= pick_b ? b_wdata : a_wdata;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // mem_addr/mem_in are left alone so the port stays quiet until the next grant.
          mem_write <= 1'b0;
          wait_cnt  <= CW'(READ_LAT - 1);
          state     <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            if (!cur_we) begin
              if (grant_b) b_rdata <= mem_dout;
              else         a_rdata <= mem_dout;
            end
            if (grant_b) b_ack <= 1'b1;
            else         a_ack <= 1'b1;
            state <= ACK;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        ACK: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef LAB5_ARB_STATS_EN
  // Per-requester grant counters. They are bumped on the IDLE->ISSUE edge and saturate at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_grants <= '0;
      b_grants <= '0;
    end else if (state == IDLE && any_req) begin
      if (pick_b) begin
        if (b_grants != 16'hFFFF) b_grants <= b_grants + 16'd1;
      end else begin
        if (a_grants != 16'hFFFF) a_grants <= a_grants + 16'd1;
      end
    end
  end
`endif

endmodule
